// File: rtl/receptor_sonar.sv
// rtl/receptor_sonar.sv - Sonar angle/distance serial frame receiver (optional feature macro: RX_PARITY_CHECK_EN)
module receptor_sonar #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro_quadro,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
    localparam logic [6:0]    CH_HASH  = 7'h23;
    localparam logic [6:0]    CH_COMMA = 7'h2C;

    typedef enum logic [2:0] {
        E_IDLE, E_START, E_DATA, E_PAR, E_STOP1, E_STOP2, E_WAIT
    } eng_t;

    typedef enum logic [2:0] {
        P_A2, P_A1, P_A0, P_VIRGULA, P_D2, P_D1, P_D0, P_TERM
    } prs_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx;

    eng_t                   eng_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_q;
    logic [6:0]             shift_q;
    logic [6:0]             char_q;
    logic                   char_valid_q;
    logic                   erro_quadro_q;
    logic                   char_err;
    logic                   sample;

    prs_t                   prs_q;
    logic [11:0]            ang_sh_q;
    logic [11:0]            dist_sh_q;
    logic [11:0]            ang_q;
    logic [11:0]            dist_q;
    logic                   pronto_q;
    logic                   erro_formato_q;
    logic                   is_digit;

    assign rx = sync_q[SYNC_STAGES-1];

    // Start-bit midpoint is half a bit after the edge; every later bit is one full bit after the previous sample.
    assign sample   = (eng_q == E_START) ? (cnt_q == HALF_BIT) : (cnt_q == FULL_BIT);
    assign is_digit = (char_q >= 7'h30) && (char_q <= 7'h39);

    // Metastability synchronizer plus one-cycle history for falling-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= SYNC_STAGES'({sync_q, entrada_serial});
            rx_prev_q <= rx;
        end
    end

`ifdef RX_PARITY_CHECK_EN
    logic par_ok_q;
    logic erro_paridade_q;
    assign erro_paridade = erro_paridade_q;
    assign char_err      = erro_quadro_q | erro_paridade_q;
`else
    assign erro_paridade = 1'b0;
    assign char_err      = erro_quadro_q;
`endif

    // Bit engine: start detect, mid-bit sampling, parity and stop checking, character hand-off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            eng_q           <= E_IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            char_q          <= '0;
            char_valid_q    <= 1'b0;
            erro_quadro_q   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            par_ok_q        <= 1'b0;
            erro_paridade_q <= 1'b0;
`endif
        end else begin
            char_valid_q  <= 1'b0;
            erro_quadro_q <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            erro_paridade_q <= 1'b0;
`endif
            if (eng_q != E_IDLE && eng_q != E_WAIT) begin
                cnt_q <= sample ? CW'(1) : cnt_q + CW'(1);
            end
            case (eng_q)
                E_IDLE: begin
                    if (rx_prev_q && !rx) begin
                        eng_q <= E_START;
                        cnt_q <= CW'(1);
                    end
                end
                E_START: begin
                    if (sample) begin
                        eng_q <= rx ? E_IDLE : E_DATA;
                        bit_q <= '0;
                    end
                end
                E_DATA: begin
                    if (sample) begin
                        shift_q <= {rx, shift_q[6:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd6) eng_q <= E_PAR;
                    end
                end
                E_PAR: begin
                    if (sample) begin
`ifdef RX_PARITY_CHECK_EN
                        par_ok_q <= ^{shift_q, rx};
`endif
                        eng_q <= E_STOP1;
                    end
                end
                E_STOP1: begin
                    if (sample) begin
                        if (!rx) begin
                            erro_quadro_q <= 1'b1;
                            eng_q         <= E_WAIT;
                        end else begin
                            eng_q <= E_STOP2;
                        end
                    end
                end
                E_STOP2: begin
                    if (sample) begin
                        if (!rx) begin
                            erro_quadro_q <= 1'b1;
                            eng_q         <= E_WAIT;
                        end else begin
                            eng_q <= E_IDLE;
`ifdef RX_PARITY_CHECK_EN
                            if (!par_ok_q) begin
                                erro_paridade_q <= 1'b1;
                            end else begin
                                char_q       <= shift_q;
                                char_valid_q <= 1'b1;
                            end
`else
                            char_q       <= shift_q;
                            char_valid_q <= 1'b1;
`endif
                        end
                    end
                end
                E_WAIT: begin
                    if (rx) eng_q <= E_IDLE;
                end
                default: eng_q <= E_IDLE;
            endcase
        end
    end

    // Frame parser: walks a2 a1 a0 ',' d2 d1 d0 '#', publishing the shadow values only on a complete frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prs_q          <= P_A2;
            ang_sh_q       <= '0;
            dist_sh_q      <= '0;
            ang_q          <= '0;
            dist_q         <= '0;
            pronto_q       <= 1'b0;
            erro_formato_q <= 1'b0;
        end else begin
            pronto_q       <= 1'b0;
            erro_formato_q <= 1'b0;
            if (char_err) begin
                prs_q <= P_A2;
            end else if (char_valid_q) begin
                if (char_q == CH_HASH) begin
                    if (prs_q == P_TERM) begin
                        ang_q    <= ang_sh_q;
                        dist_q   <= dist_sh_q;
                        pronto_q <= 1'b1;
                    end else begin
                        erro_formato_q <= 1'b1;
                    end
                    prs_q <= P_A2;
                end else begin
                    case (prs_q)
                        P_A2, P_A1, P_A0, P_D2, P_D1, P_D0: begin
                            if (is_digit) begin
                                case (prs_q)
                                    P_A2:    ang_sh_q[11:8]  <= char_q[3:0];
                                    P_A1:    ang_sh_q[7:4]   <= char_q[3:0];
                                    P_A0:    ang_sh_q[3:0]   <= char_q[3:0];
                                    P_D2:    dist_sh_q[11:8] <= char_q[3:0];
                                    P_D1:    dist_sh_q[7:4]  <= char_q[3:0];
                                    default: dist_sh_q[3:0]  <= char_q[3:0];
                                endcase
                                prs_q <= prs_t'(prs_q + 3'd1);
                            end else begin
                                erro_formato_q <= 1'b1;
                                prs_q          <= P_A2;
                            end
                        end
                        P_VIRGULA: begin
                            if (char_q == CH_COMMA) begin
                                prs_q <= P_D2;
                            end else begin
                                erro_formato_q <= 1'b1;
                                prs_q          <= P_A2;
                            end
                        end
                        default: begin
                            erro_formato_q <= 1'b1;
                            prs_q          <= P_A2;
                        end
                    endcase
                end
            end
        end
    end

    assign angulo       = ang_q;
    assign distancia    = dist_q;
    assign pronto       = pronto_q;
    assign erro_quadro  = erro_quadro_q;
    assign erro_formato = erro_formato_q;
    assign db_estado    = {1'b0, prs_q};

endmodule

// File: tb/tb_receptor_sonar.sv
// tb/tb_receptor_sonar.sv - Scoreboard bench for receptor_sonar with a frame-level reference model
`timescale 1ns/1ps
module tb_receptor_sonar;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        pronto;
    logic        erro_quadro;
    logic        erro_paridade;
    logic        erro_formato;
    logic [3:0]  db_estado;

    receptor_sonar #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .angulo         (angulo),
        .distancia      (distancia),
        .pronto         (pronto),
        .erro_quadro    (erro_quadro),
        .erro_paridade  (erro_paridade),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // kinds: 0 pronto, 1 erro_quadro, 2 erro_paridade, 3 erro_formato
    typedef struct {
        int          kind;
        logic [11:0] a;
        logic [11:0] d;
    } ev_t;

    ev_t         exp_q[$];
    logic [6:0]  frame_q[$];
    logic [11:0] cur_ang  = '0;
    logic [11:0] cur_dist = '0;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit fits(input int pos, input logic [6:0] c);
        if (pos >= 7) return 1'b0;
        if (pos == 3) return c == 7'h2C;
        return (c >= 7'h30) && (c <= 7'h39);
    endfunction

    // Reference model: a character either extends a valid frame prefix, completes it with '#', or aborts it.
    task automatic expect_char(input logic [6:0] c, input bit bad_stop, input bit bad_par);
        ev_t e;
        e.a = '0;
        e.d = '0;
        if (bad_stop) begin
            e.kind = 1;
            exp_q.push_back(e);
            frame_q.delete();
            return;
        end
`ifdef RX_PARITY_CHECK_EN
        if (bad_par) begin
            e.kind = 2;
            exp_q.push_back(e);
            frame_q.delete();
            return;
        end
`endif
        if (c == 7'h23) begin
            if (frame_q.size() == 7) begin
                e.kind = 0;
                e.a = {frame_q[0][3:0], frame_q[1][3:0], frame_q[2][3:0]};
                e.d = {frame_q[4][3:0], frame_q[5][3:0], frame_q[6][3:0]};
            end else begin
                e.kind = 3;
            end
            exp_q.push_back(e);
            frame_q.delete();
        end else if (fits(frame_q.size(), c)) begin
            frame_q.push_back(c);
        end else begin
            e.kind = 3;
            exp_q.push_back(e);
            frame_q.delete();
        end
    endtask

    task automatic drive_bit(input logic b);
        entrada_serial = b;
        repeat (CPB) @(negedge clock);
    endtask

    // stop_sel: 0 good stops, 1 both stop bits low, 2 second stop bit low
    task automatic send_char(input logic [6:0] c, input int stop_sel, input bit bad_par, input bit gap);
        logic p;
        expect_char(c, stop_sel != 0, bad_par);
        p = ~^c;
        if (bad_par) p = ~p;
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(c[i]);
        drive_bit(p);
        drive_bit(stop_sel == 1 ? 1'b0 : 1'b1);
        drive_bit(stop_sel != 0 ? 1'b0 : 1'b1);
        if (stop_sel != 0 && gap) drive_bit(1'b1);
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 0, 1'b0, 1'b0);
        end
    endtask

    // Monitor: pops the expected event whenever the DUT pulses and tracks the last published values.
    always @(negedge clock) begin
        int   n;
        int   act;
        ev_t  e;
        if (reset) begin
            n = int'(pronto) + int'(erro_quadro) + int'(erro_paridade) + int'(erro_formato);
            chk("one_pulse_max", n <= 1, 1);
            if (n >= 1) begin
                act = pronto ? 0 : erro_quadro ? 1 : erro_paridade ? 2 : 3;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", act, e.kind);
                    if (e.kind == 0 && act == 0) begin
                        cur_ang  = e.a;
                        cur_dist = e.d;
                    end
                end
            end
            chk("angulo_hold", angulo, cur_ang);
            chk("distancia_hold", distancia, cur_dist);
        end
    end

    initial begin
        logic [6:0] fr[8];
        int         ssel;
        bit         bpar;

        repeat (3) @(negedge clock);
        chk("rst_angulo", angulo, 12'h000);
        chk("rst_distancia", distancia, 12'h000);
        chk("rst_pulses", {pronto, erro_quadro, erro_paridade, erro_formato}, 4'b0000);
        chk("rst_db_estado", db_estado, 4'd0);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clock);

        send_str("045,123#");
        chk("basic_angulo", angulo, 12'h045);
        chk("basic_distancia", distancia, 12'h123);

        send_str("090,0");
        send_str("#");
        chk("resync_hold", angulo, 12'h045);
        send_str("020,050#");
        chk("resync_angulo", angulo, 12'h020);
        chk("resync_distancia", distancia, 12'h050);

        send_char(7'h31, 1, 1'b0, 1'b0);
        repeat (20) drive_bit(1'b0);
        repeat (2) drive_bit(1'b1);
        send_str("160,200#");
        chk("break_angulo", angulo, 12'h160);
        chk("break_distancia", distancia, 12'h200);

        send_str("170,00");
        send_char(7'h37, 0, 1'b1, 1'b0);
        send_str("#");
`ifdef RX_PARITY_CHECK_EN
        chk("par_distancia", distancia, 12'h200);
`else
        chk("par_distancia", distancia, 12'h007);
`endif

        send_str("030,4");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b0;
        entrada_serial = 1'b1;
        frame_q.delete();
        cur_ang  = '0;
        cur_dist = '0;
        repeat (3) @(negedge clock);
        chk("midrst_angulo", angulo, 12'h000);
        chk("midrst_distancia", distancia, 12'h000);
        chk("midrst_db_estado", db_estado, 4'd0);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        send_str("030,456#");
        chk("postrst_angulo", angulo, 12'h030);
        chk("postrst_distancia", distancia, 12'h456);

        entrada_serial = 1'b0;
        repeat (5) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        chk("glitch_db_estado", db_estado, 4'd0);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) fr[i] = 7'h30 + 7'($urandom_range(0, 9));
            fr[3] = 7'h2C;
            fr[7] = 7'h23;
            if ($urandom_range(0, 3) == 0) fr[$urandom_range(0, 7)] = 7'($urandom_range(32, 126));
            for (int i = 0; i < 8; i++) begin
                ssel = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
                bpar = ($urandom_range(0, 7) == 0);
                send_char(fr[i], ssel, bpar, 1'b1);
            end
        end

        send_str("#");
        send_str("987,654#");

        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_angulo", angulo, 12'h987);
        chk("final_distancia", distancia, 12'h654);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
